csi_packet_tx: RTL and testbench
================================

// Module: csi_packet_tx
// PURPOSE
//  Transmit-side packet framer for the 2-lane CSI-2 byte path: the counterpart of the receive-side header finder.
//  Accepts a 32-bit packet header and a 16-bit payload stream, and emits a 16-bit word stream for the lane distributor.
//  Stream order: header low half, header high half, payload, then CRC-16 footer for long packets.
//  Each word carries byte1 = [7:0] and byte2 = [15:8].
// PARAMETERS
//  LONG_DT_MIN  6'h10  smallest data type (PH[5:0]) treated as a long packet; lower values are short packets
// PORTS
//  txbyteclkhs  in   1   byte clock; all logic on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  ph_in        in   32  {ECC[31:24], WC[23:8], DI[7:0]}
//  ph_valid     in   1   ph_in valid
//  ph_ready     out  1   header accepted when ph_valid & ph_ready
//  data_in      in   16  payload word, byte1 = [7:0] sent/CRC'd first
//  data_valid   in   1   data_in valid
//  data_ready   out  1   payload word accepted when data_valid & data_ready
//  word_out     out  16  output word
//  out_valid    out  1   word_out valid
//  out_ready    in   1   downstream accepts word_out when out_valid & out_ready
//  out_sop      out  1   word_out is header low half
//  out_eop      out  1   word_out is last word of the packet
//  busy         out  1   state != IDLE or out_valid
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, word_out=0, out_valid=0, out_sop=0, out_eop=0, ph_ready=0, data_ready=0, counters and CRC cleared.
//    Reset mid-packet abandons the packet; no partial word remains valid after release.
//  - Output register slot is free when !out_valid | out_ready.
//    word_out/out_valid/sop/eop hold stable while out_valid & !out_ready.
//  - Throughput: 1 word/cycle; first word appears the cycle after the header handshake.
//  - FSM:
//    - IDLE: ph_ready=1 when slot is free.
//      - On accept: latch PH; load wc_words = WC[15:1] + WC[0], so an odd WC rounds up.
//      - Load word 0 = PH[15:0], set sop; go to PH_HI.
//    - PH_HI: when slot is free, load PH[31:16].
//      - Short packet (DT < LONG_DT_MIN): set eop, go to IDLE.
//      - Long packet, wc_words == 0: go to CRC.
//      - Otherwise: go to PAYLOAD.
//    - PAYLOAD: data_ready = slot free.
//      - Each accepted word is loaded into output and folded into the CRC; decrement wc_words.
//      - When the last word is accepted, go to CRC.
//      - Odd WC: the upper byte of the final word is transmitted as given but excluded from the CRC.
//    - CRC: when slot is free, load word_out = crc[15:0] (crc[7:0] is byte1), set eop, clear CRC to seed, go to IDLE.
//  - CRC-16:
//    - Polynomial x^16+x^12+x^5+1, reflected (0x8408), seed 16'hFFFF.
//    - Bytes processed LSB-first, no final XOR (CRC-16/MCRF4XX).
//    - Seeded at every header accept.
//  - Header fields are passed unmodified; ECC is not generated or checked here.
//  - data_in is ignored outside PAYLOAD; data_ready=0 there.
//  - Back-to-back packets: IDLE accepts the next header in the same cycle the prior eop word leaves the slot.
//  - Simultaneous out_ready and a new load in the same cycle: the new word replaces the old one, with no bubble.
// TESTING
//  - Short packet: PH=32'h2B_0000_00 (DT 0x00) -> words 16'h0000, 16'h2B00; sop on 1st, eop on 2nd; data_ready never high.
//  - Long, WC=0: PH=32'h1A_0000_2A -> 16'h002A, 16'h1A00, 16'hFFFF (eop); 3 consecutive cycles with out_ready=1.
//  - Long, WC=4, data 16'h3231, 16'h3433 -> 2 header words, 2 payload words, CRC word matching the MCRF4XX model of "1234".
//    Model check value is 0x6F91 for "123456789".
//  - Odd WC=9 over "123456789" (5 words, last upper byte 0xAA) -> 5 payload words incl. 16'hAA39; footer 16'h6F91.
//  - Backpressure: toggle out_ready randomly during a WC=64 packet -> no word lost or duplicated; word_out stable while stalled.
//  - Reset mid-payload: assert reset_n=0 after 3 payload words -> out_valid=0 immediately; after release, the next header is framed correctly with CRC reseeded.

Source files
------------

// File: rtl/csi_packet_tx.sv
// csi_packet_tx: CSI-2 transmit framer, header + payload + CRC-16/MCRF4XX footer onto a 16-bit word stream
module csi_packet_tx #(
  parameter logic [5:0] LONG_DT_MIN = 6'h10
) (
  input  logic        txbyteclkhs,
  input  logic        reset_n,
  input  logic [31:0] ph_in,
  input  logic        ph_valid,
  output logic        ph_ready,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [15:0] word_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, PH_HI, PAYLOAD, CRC} state_e;
  state_e      state_q, state_d;
  logic [15:0] ph_hi_q, ph_hi_d, wc_q, wc_d, crc_q, crc_d, word_q, word_d;
  logic        long_q, long_d, odd_q, odd_d, valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic        slot_free;
  logic [15:0] crc_lo, crc_hi;
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction
  always_comb begin
    slot_free  = !valid_q | out_ready;
    state_d    = state_q;
    ph_hi_d    = ph_hi_q;
    long_d     = long_q;
    odd_d      = odd_q;
    wc_d       = wc_q;
    crc_d      = crc_q;
    word_d     = word_q;
    valid_d    = valid_q & !out_ready;
    sop_d      = sop_q;
    eop_d      = eop_q;
    ph_ready   = 1'b0;
    data_ready = 1'b0;
    crc_lo     = crc_byte(crc_q, data_in[7:0]);
    crc_hi     = crc_byte(crc_lo, data_in[15:8]);
    unique case (state_q)
      IDLE: begin
        ph_ready = reset_n & slot_free;
        if (ph_valid & ph_ready) begin
          ph_hi_d = ph_in[31:16];
          long_d  = ph_in[5:0] >= LONG_DT_MIN;
          odd_d   = ph_in[8];
          wc_d    = {1'b0, ph_in[23:9]} + {15'd0, ph_in[8]};
          crc_d   = 16'hFFFF;
          word_d  = ph_in[15:0];
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
          state_d = PH_HI;
        end
      end
      PH_HI: if (slot_free) begin
        word_d  = ph_hi_q;
        valid_d = 1'b1;
        sop_d   = 1'b0;
        eop_d   = !long_q;
        state_d = !long_q ? IDLE : (wc_q == 16'd0 ? CRC : PAYLOAD);
      end
      PAYLOAD: begin
        data_ready = slot_free;
        if (data_valid & slot_free) begin
          word_d  = data_in;
          valid_d = 1'b1;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
          // an odd word count leaves a pad byte in the final word's upper half
          crc_d   = (wc_q == 16'd1 && odd_q) ? crc_lo : crc_hi;
          wc_d    = wc_q - 16'd1;
          state_d = wc_q == 16'd1 ? CRC : PAYLOAD;
        end
      end
      default: if (slot_free) begin
        word_d  = crc_q;
        valid_d = 1'b1;
        sop_d   = 1'b0;
        eop_d   = 1'b1;
        crc_d   = 16'hFFFF;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge txbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ph_hi_q <= '0;
      long_q  <= 1'b0;
      odd_q   <= 1'b0;
      wc_q    <= '0;
      crc_q   <= 16'hFFFF;
      word_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_hi_q <= ph_hi_d;
      long_q  <= long_d;
      odd_q   <= odd_d;
      wc_q    <= wc_d;
      crc_q   <= crc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end
  assign word_out  = word_q;
  assign out_valid = valid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign busy      = (state_q != IDLE) | valid_q;
endmodule

// File: tb/tb_csi_packet_tx.sv
// tb_csi_packet_tx: directed framing tests with a queue scoreboard and a decoupled output monitor
module tb_csi_packet_tx;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ph_in = '0;
  logic        ph_valid = 1'b0;
  logic        ph_ready;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [15:0] word_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sop, out_eop, busy;
  int          checks = 0, errors = 0, cyc = 0, sop_cyc = 0, eop_cyc = 0, sop_gap = 0;
  logic [17:0] exp_q[$];
  logic [17:0] held;
  logic        held_v = 1'b0, rand_bp = 1'b0, dr_seen = 1'b0;
  logic [15:0] eop_word = '0;
  logic [15:0] pl[64];
  csi_packet_tx dut (
    .txbyteclkhs(clk), .reset_n(reset_n), .ph_in(ph_in), .ph_valid(ph_valid), .ph_ready(ph_ready),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready), .word_out(word_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    logic [17:0] e;
    cyc++;
    if (data_ready) dr_seen = 1'b1;
    if (!reset_n) held_v = 1'b0;
    else begin
      if (held_v) begin
        checks++;
        if ({out_sop, out_eop, word_out} !== held || !out_valid) begin
          errors++;
          $display("FAIL stall_hold got %h valid %b need %h", {out_sop, out_eop, word_out}, out_valid, held);
        end
      end
      held_v = out_valid && !out_ready;
      held = {out_sop, out_eop, word_out};
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got %h", {out_sop, out_eop, word_out});
        end else begin
          e = exp_q.pop_front();
          if ({out_sop, out_eop, word_out} !== e) begin
            errors++;
            $display("FAIL word sop/eop/word got %h need %h", {out_sop, out_eop, word_out}, e);
          end
        end
        if (out_sop) begin sop_gap = cyc - eop_cyc; sop_cyc = cyc; end
        if (out_eop) begin eop_cyc = cyc; eop_word = word_out; end
      end
    end
  end
  function automatic logic [15:0] mcrf(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got %h need %h", name, got, need);
    end
  endtask
  task automatic send_hdr(input logic [31:0] ph);
    bit ok = 0;
    ph_in = ph;
    ph_valid = 1'b1;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      ok = ph_ready;
    end
    if (!ok) check("hdr_timeout", 0, 1);
    @(posedge clk);
    #1 ph_valid = 1'b0;
  endtask
  task automatic send_data(input logic [15:0] w);
    bit ok = 0;
    data_in = w;
    data_valid = 1'b1;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      ok = data_ready;
    end
    if (!ok) check("data_timeout", 0, 1);
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask
  task automatic send_pkt(input logic [31:0] ph);
    bit lng = ph[5:0] >= 6'h10;
    int wc = int'(ph[23:8]);
    int nw = (wc + 1) / 2;
    logic [15:0] c = 16'hFFFF;
    exp_q.push_back({2'b10, ph[15:0]});
    exp_q.push_back({1'b0, !lng, ph[31:16]});
    send_hdr(ph);
    if (lng) begin
      for (int i = 0; i < nw; i++) begin
        exp_q.push_back({2'b00, pl[i]});
        c = mcrf(c, pl[i][7:0]);
        if (!(i == nw - 1 && wc % 2 == 1)) c = mcrf(c, pl[i][15:8]);
        send_data(pl[i]);
      end
      exp_q.push_back({2'b01, c});
    end
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = exp_q.size() == 0 && !busy;
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_word", 32'(word_out), 0);
    check("rst_sop_eop", 32'({out_sop, out_eop}), 0);
    check("rst_readies", 32'({ph_ready, data_ready}), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("idle_ph_ready", 32'(ph_ready), 1);
    @(posedge clk);
    #1;
    dr_seen = 1'b0;
    send_pkt(32'h2B00_0000);
    wait_idle();
    check("short_no_data_ready", 32'(dr_seen), 0);
    send_pkt(32'h1A00_002A);
    wait_idle();
    check("wc0_cycles", 32'(eop_cyc - sop_cyc), 2);
    check("wc0_footer", 32'(eop_word), 32'h0000_FFFF);
    pl[0] = 16'h3231; pl[1] = 16'h3433;
    send_pkt(32'h0000_042A);
    wait_idle();
    pl[0] = 16'h3231; pl[1] = 16'h3433; pl[2] = 16'h3635; pl[3] = 16'h3837; pl[4] = 16'hAA39;
    send_pkt(32'h0000_092A);
    wait_idle();
    check("odd_footer", 32'(eop_word), 32'h0000_6F91);
    send_pkt(32'h0500_0001);
    send_pkt(32'h0600_0002);
    wait_idle();
    check("b2b_gap", 32'(sop_gap), 1);
    for (int i = 0; i < 32; i++) pl[i] = {8'(i * 3 + 1), 8'(i * 7 + 2)};
    rand_bp = 1'b1;
    send_pkt(32'h7700_402B);
    wait_idle();
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back({2'b10, 16'h082A});
    exp_q.push_back({2'b00, 16'h0000});
    send_hdr(32'h0000_082A);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b00, 16'h5550 + 16'(i)});
      send_data(16'h5550 + 16'(i));
    end
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    pl[0] = 16'h3231; pl[1] = 16'h3433;
    send_pkt(32'h0000_042A);
    wait_idle();
    check("post_rst_footer", 32'(eop_word), 32'(mcrf(mcrf(mcrf(mcrf(16'hFFFF, 8'h31), 8'h32), 8'h33), 8'h34)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
